// File: rtl/vtisa_pkg.sv
// Shared ISA definitions: instruction width, opcodes and the fetch state encoding.
package vtisa_pkg;

    localparam int INSTR_WIDTH = 8;

    localparam logic [4:0] OP_LI = 5'b00001;
    localparam logic [4:0] OP_LD = 5'b00010;
    localparam logic [4:0] OP_ST = 5'b00011;

    // REQ: fetch outstanding for pc; VALID: instr holds pc's instruction;
    // FLUSH: a redirected fetch is waiting for its stale data to drain.
    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_VALID = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry prefetch buffer holding the instruction at pc+1.
// Only present when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module fetch_buffer
    import vtisa_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] data
);

    // Clear wins over load; data is only meaningful while valid is set.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests instructions from a one-cycle-ack memory,
// hands them to the decoder and handles redirects (jumps).
// Optional feature macro: FETCH_PREFETCH_EN (one-entry prefetch of pc+1).
//
// Memory handshake: imem_req/imem_addr are held stable from the cycle the
// request is raised until the cycle imem_ack is seen high; imem_rdata is only
// valid in that ack cycle. The decoder side uses fetch_source as "valid" and
// increment_pc as "consumed"; increment_pc has no effect while fetch_source=0.
module fetch_unit
    import vtisa_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   increment_pc,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   fetch_source,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [1:0]             fsm_state
);

    localparam logic [1:0] ST_REQ   = FETCH_REQ;
    localparam logic [1:0] ST_VALID = FETCH_VALID;
    localparam logic [1:0] ST_FLUSH = FETCH_FLUSH;

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] flush_addr;  // address of the request being drained
    logic                drop_ack;    // first cycle after reset: stale ack
    logic                ack_ok;
    logic [PC_WIDTH-1:0] pc_inc;

    assign ack_ok    = imem_ack && !drop_ack;
    assign pc_inc    = pc + 1'b1;
    assign fsm_state = state;

`ifdef FETCH_PREFETCH_EN
    logic                   buf_valid;
    logic [INSTR_WIDTH-1:0] buf_data;
    logic                   buf_load;
    logic                   buf_clear;

    // Prefetch data parks in the buffer only when the decoder is not
    // consuming this cycle; any exit from VALID or a consume empties it.
    assign buf_load  = (state == ST_VALID) && !buf_valid && ack_ok &&
                       !increment_pc && !jump_en;
    assign buf_clear = (state != ST_VALID) || jump_en || increment_pc;

    fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_data (imem_rdata),
        .valid     (buf_valid),
        .data      (buf_data)
    );

    // In VALID the unit keeps fetching pc+1 until the buffer is full.
    assign imem_req  = !reset && ((state != ST_VALID) || !buf_valid);
    assign imem_addr = (state == ST_FLUSH) ? flush_addr :
                       (state == ST_VALID) ? pc_inc : pc;
`else
    assign imem_req  = !reset && (state != ST_VALID);
    assign imem_addr = (state == ST_FLUSH) ? flush_addr : pc;
`endif

    // Sequencing of requests, redirects and instruction hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            instr        <= '0;
            fetch_source <= 1'b0;
            flush_addr   <= RESET_PC;
            drop_ack     <= 1'b1;
        end else begin
            drop_ack <= 1'b0;
            case (state)
                ST_REQ: begin
                    if (jump_en) begin
                        // pc doubles as the latched target while draining.
                        pc         <= jump_target;
                        flush_addr <= pc;
                        state      <= ack_ok ? ST_REQ : ST_FLUSH;
                    end else if (ack_ok) begin
                        instr        <= imem_rdata;
                        fetch_source <= 1'b1;
                        state        <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (jump_en) begin
                        pc           <= jump_target;
                        fetch_source <= 1'b0;
`ifdef FETCH_PREFETCH_EN
                        flush_addr   <= pc_inc;
                        state        <= (!buf_valid && !ack_ok) ? ST_FLUSH : ST_REQ;
`else
                        state        <= ST_REQ;
`endif
                    end else if (increment_pc) begin
                        pc <= pc_inc;
`ifdef FETCH_PREFETCH_EN
                        if (buf_valid) begin
                            instr <= buf_data;
                        end else if (ack_ok) begin
                            instr <= imem_rdata;
                        end else begin
                            // Prefetch still outstanding at the new pc: keep it.
                            fetch_source <= 1'b0;
                            state        <= ST_REQ;
                        end
`else
                        fetch_source <= 1'b0;
                        state        <= ST_REQ;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (jump_en) begin
                        pc <= jump_target;
                    end
                    if (ack_ok) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run against a transaction-level model of the program flow.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       increment_pc;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic       fetch_source;
  logic [7:0] pc;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  // model of the program flow for the randomized run
  logic [7:0] exp_pc;
  bit         stale;
  bit         prev_req, prev_acc, prev_fs, prev_inc, prev_jmp, prev_stale;
  logic [7:0] prev_addr;
  int         lat, wait_cnt;

  // clock / reset
  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .increment_pc (increment_pc),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .fetch_source (fetch_source),
    .pc           (pc),
    .fsm_state    (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for one cycle, return 1 time unit after the edge
  task automatic cycle(input logic a, input logic [7:0] d, input logic inc,
                       input logic j, input logic [7:0] t);
    imem_ack     = a;
    imem_rdata   = d;
    increment_pc = inc;
    jump_en      = j;
    jump_target  = t;
    @(posedge clk);
    #1;
  endtask

  // one fetch from REQ with a given ack latency, then consume it
  task automatic serial_fetch(input int latency, input logic [7:0] addr);
    exp_q.push_back(mem[addr]);
    check("ser_req", imem_req, 1'b1);
    check("ser_addr", imem_addr, addr);
    check("ser_fs_low", fetch_source, 1'b0);
    for (int i = 0; i < latency; i++) begin
      cycle(1'b0, 8'($urandom), 1'b1, 1'b0, 8'h00);
      check("ser_addr_hold", imem_addr, addr);
      check("ser_fs_wait", fetch_source, 1'b0);
      check("ser_pc_wait", pc, addr);
    end
    cycle(1'b1, mem[addr], 1'b1, 1'b0, 8'h00);
    check("ser_fs_high", fetch_source, 1'b1);
    check("ser_instr", instr, exp_q.pop_front());
    check("ser_pc", pc, addr);
    check("ser_req_idle", imem_req, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("ser_fs_consumed", fetch_source, 1'b0);
  endtask

  // one randomized cycle: check against the model, respond as memory, update model
  task automatic rand_cycle();
    logic       fs, rq, a, inc, j, held, e;
    logic [7:0] ad, t, d;
    fs = fetch_source;
    rq = imem_req;
    ad = imem_addr;
    held = prev_req && !prev_acc;
    check("rnd_pc", pc, exp_pc);
    if (fs) check("rnd_instr", instr, mem[exp_pc]);
    if (held) begin
      check("rnd_req_hold", rq, 1'b1);
      check("rnd_addr_hold", ad, prev_addr);
    end
`ifndef FETCH_PREFETCH_EN
    if (fs) check("rnd_req_idle", rq, 1'b0);
    if (rq && !held) check("rnd_new_addr", ad, exp_pc);
    if (prev_acc) e = !prev_stale && !prev_jmp;
    else if (prev_fs) e = !(prev_inc || prev_jmp);
    else e = 1'b0;
    check("rnd_fetch_source", fs, e);
`endif
    if (rq && !held) begin
      stale = 1'b0;
      wait_cnt = 0;
      lat = $urandom_range(0, 3);
    end
    a = rq && (wait_cnt >= lat);
    wait_cnt++;
    j = ($urandom_range(0, 5) == 0);
    t = 8'($urandom);
    inc = 1'($urandom_range(0, 1));
    d = a ? mem[ad] : 8'($urandom);
    prev_stale = stale;
    if (fs) begin
      if (j) exp_pc = t;
      else if (inc) exp_pc = exp_pc + 8'd1;
    end else if (j) begin
      exp_pc = t;
      stale = 1'b1;
    end
    prev_req = rq; prev_acc = a; prev_addr = ad;
    prev_fs = fs; prev_inc = inc; prev_jmp = j;
    cycle(a, d, inc, j, t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h09;
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = 8'h00; increment_pc = 1'b0;
    jump_en = 1'b0; jump_target = 8'h00;
    repeat (3) begin @(posedge clk); #1; end

    // reset state
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, 8'h00);
    check("rst_fs", fetch_source, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_state", fsm_state, 2'd0);

    // release: request rises at once, ack after two cycles
    reset = 1'b0;
    #1;
    check("rel_req", imem_req, 1'b1);
    check("rel_addr", imem_addr, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 8'h09, 1'b0, 1'b0, 8'h00);
    check("first_instr", instr, 8'h09);
    check("first_fs", fetch_source, 1'b1);
    check("first_pc", pc, 8'h00);

`ifndef FETCH_PREFETCH_EN
    // jump and increment together in VALID: jump wins
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
    check("jmp_prio_pc", pc, 8'h00);
    check("jmp_prio_fs", fetch_source, 1'b0);
    check("jmp_prio_addr", imem_addr, 8'h00);

    // serial fetch with ack latencies 0, 3, 1
    serial_fetch(0, 8'h00);
    serial_fetch(3, 8'h01);
    serial_fetch(1, 8'h02);

    // jump in REQ coinciding with ack: data dropped, next request at target
    cycle(1'b1, mem[3], 1'b0, 1'b1, 8'hFF);
    check("jmp_ack_fs", fetch_source, 1'b0);
    check("jmp_ack_addr", imem_addr, 8'hFF);
    check("jmp_ack_pc", pc, 8'hFF);

    // pc wrap-around
    serial_fetch(1, 8'hFF);
    check("wrap_addr", imem_addr, 8'h00);
    check("wrap_pc", pc, 8'h00);

    // jump while request outstanding, retargeted during the flush
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
    check("flush_addr0", imem_addr, 8'h00);
    check("flush_pc0", pc, 8'h55);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h40);
    check("flush_addr1", imem_addr, 8'h00);
    check("flush_pc1", pc, 8'h40);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("flush_addr2", imem_addr, 8'h00);
    check("flush_req2", imem_req, 1'b1);
    cycle(1'b1, mem[0], 1'b0, 1'b0, 8'h00);
    check("flush_drop_fs", fetch_source, 1'b0);
    check("flush_next_addr", imem_addr, 8'h40);
    serial_fetch(0, 8'h40);

    // reset mid-request; ack in the next cycle is ignored
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("midrst_req", imem_req, 1'b0);
    check("midrst_pc", pc, 8'h00);
    reset = 1'b0;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    check("midrst_fs", fetch_source, 1'b0);
    check("midrst_instr", instr, 8'h00);
    check("midrst_addr", imem_addr, 8'h00);
    serial_fetch(2, 8'h00);
`else
    // zero-bubble streaming with latency-0 memory
    for (int k = 1; k <= 10; k++) begin
      cycle(imem_req, mem[imem_addr], 1'b1, 1'b0, 8'h00);
      check("pf_fs", fetch_source, 1'b1);
      check("pf_pc", pc, 8'(k));
      check("pf_instr", instr, mem[8'(k)]);
    end
`endif

    // randomized run from a fresh reset
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    exp_pc = 8'h00; stale = 1'b0;
    prev_req = 1'b0; prev_acc = 1'b0; prev_fs = 1'b0;
    prev_inc = 1'b0; prev_jmp = 1'b0; prev_stale = 1'b0;
    prev_addr = 8'h00; lat = 0; wait_cnt = 0;
    for (int n = 0; n < 400; n++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
